// File: rtl/tt_sweep_checker.sv
// Truth-table sweep stage: walks a 3-input netlist through rows 0..7, captures each output
// after a settle window and compares the result with EXPECTED_TT.
// Optional: TT_SWEEP_STABILITY_CHECK_EN adds a per-row output stability check (unstable_mask).
`timescale 1ns / 1ps

module tt_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED_TT   = 8'h89
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] tt_captured,
  output logic [7:0] mismatch
`ifdef TT_SWEEP_STABILITY_CHECK_EN
  ,
  output logic [7:0] unstable_mask
`endif
);

  localparam int unsigned CntW = ($clog2(SETTLE_CYCLES + 1) > 1) ?
                                 $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      tt_q, tt_d, tt_cap;
  logic [7:0]      mis_q, mis_d;
  logic            pass_q, pass_d;
  logic [2:0]      bit_idx;

`ifdef TT_SWEEP_STABILITY_CHECK_EN
  localparam logic [CntW-1:0] CntPre = CntW'(SETTLE_CYCLES - 1);
  logic [7:0] unst_q, unst_d, unst_cap;
  logic       pre_q, pre_d;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mis_d   = mis_q;
    pass_d  = pass_q;
    // Row 0 lands in the MSB so the table reads like the netlist's hex code.
    bit_idx = 3'd7 - row_q;
    tt_cap  = tt_q;
    tt_cap[bit_idx] = dut_out;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
    unst_d   = unst_q;
    pre_d    = pre_q;
    unst_cap = unst_q;
    unst_cap[bit_idx] = unst_q[bit_idx] | (pre_q != dut_out);
`endif

    unique case (state_q)
      StIdle: begin
        row_d = 3'd0;
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          tt_d    = 8'h00;
          mis_d   = 8'h00;
          pass_d  = 1'b0;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
          unst_d  = 8'h00;
`endif
        end
      end
      StRun: begin
        if (cnt_q == CntMax) begin
          tt_d  = tt_cap;
          cnt_d = '0;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
          unst_d = unst_cap;
`endif
          if (row_q == 3'd7) begin
            state_d = StDone;
            mis_d   = tt_cap ^ EXPECTED_TT;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
            pass_d  = (tt_cap == EXPECTED_TT) && (unst_cap == 8'h00);
`else
            pass_d  = (tt_cap == EXPECTED_TT);
`endif
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
          if (cnt_q == CntPre) pre_d = dut_out;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
        row_d   = 3'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= 3'd0;
      cnt_q   <= '0;
      tt_q    <= 8'h00;
      mis_q   <= 8'h00;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
    end
  end

`ifdef TT_SWEEP_STABILITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unst_q <= 8'h00;
      pre_q  <= 1'b0;
    end else begin
      unst_q <= unst_d;
      pre_q  <= pre_d;
    end
  end

  assign unstable_mask = unst_q;
`endif

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign tt_captured = tt_q;
  assign mismatch    = mis_q;
  assign {drv_in1, drv_in2, drv_in3} = busy ? row_q : 3'b000;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: behavioural netlist models feed the DUT, expected results are
// queued per sweep and compared when done pulses.
`timescale 1ns / 1ps

module tb_tt_sweep_checker;

  localparam int unsigned S = 4;
  localparam int unsigned Lat = 8 * (S + 1);

  typedef struct packed {
    logic [7:0] tt;
    logic [7:0] mis;
    logic       pass;
    logic [7:0] unst;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       drv_in1, drv_in2, drv_in3;
  logic       dut_out;
  logic       busy, done, pass;
  logic [7:0] tt_captured, mismatch;
  logic [7:0] unst_obs;

  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   done_cnt = 0;
  int   mode = 0;
  int   row2_cyc = 0;
  exp_t sb_q[$];
  int   trace_q[$];

  logic [7:0] model_tt;
  logic [2:0] r;

  tt_sweep_checker #(
    .SETTLE_CYCLES(S),
    .EXPECTED_TT  (8'h89)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .drv_in1      (drv_in1),
    .drv_in2      (drv_in2),
    .drv_in3      (drv_in3),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .tt_captured  (tt_captured),
`ifdef TT_SWEEP_STABILITY_CHECK_EN
    .mismatch     (mismatch),
    .unstable_mask(unst_obs)
`else
    .mismatch     (mismatch)
`endif
  );

`ifndef TT_SWEEP_STABILITY_CHECK_EN
  assign unst_obs = 8'h00;
`endif

  always #5 clk = ~clk;

  // Netlist models: 0 ideal 0x89, 1 tied low, 2 inverted, 3 ideal but glitchy on row 2.
  always_comb begin
    case (mode)
      1:       model_tt = 8'h00;
      2:       model_tt = 8'h76;
      default: model_tt = 8'h89;
    endcase
    r = {drv_in1, drv_in2, drv_in3};
    dut_out = model_tt[3'd7 - r];
    if (mode == 3 && r == 3'd2 && row2_cyc < int'(S)) dut_out = ~dut_out;
  end

  always @(posedge clk) row2_cyc <= (busy && r == 3'd2) ? row2_cyc + 1 : 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("tt_captured", {24'd0, tt_captured}, {24'd0, e.tt});
        check_eq("mismatch", {24'd0, mismatch}, {24'd0, e.mis});
        check_eq("pass", {31'd0, pass}, {31'd0, e.pass});
        check_eq("busy_in_done", {31'd0, busy}, 32'd0);
        check_eq("drv_in_done", {29'd0, r}, 32'd0);
`ifdef TT_SWEEP_STABILITY_CHECK_EN
        check_eq("unstable_mask", {24'd0, unst_obs}, {24'd0, e.unst});
`endif
      end
    end
  end

  task automatic push_exp(input logic [7:0] ett, input logic ep, input logic [7:0] eun);
    exp_t e;
    e.tt   = ett;
    e.mis  = ett ^ 8'h89;
    e.pass = ep;
    e.unst = eun;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_sweep(input int m, input logic [7:0] ett, input logic ep,
                           input logic [7:0] eun, input bit poke);
    int  k;
    int  d0;
    int  bad;
    bit  poked;
    mode = m;
    d0 = done_cnt;
    push_exp(ett, ep, eun);
    pulse_start();
    trace_q.delete();
    k = 0;
    poked = 1'b0;
    @(negedge clk);
    while (!done && k < 200) begin
      trace_q.push_back(int'(r));
      if (poke && !poked && r == 3'd3) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("done_latency", k, Lat);
    bad = 0;
    foreach (trace_q[i]) if (trace_q[i] != i / int'(S + 1)) bad++;
    check_eq("drv_sequence", bad, 0);
    check_eq("drv_trace_len", trace_q.size(), Lat);
    repeat (3) @(negedge clk);
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("idle_after_done", {31'd0, busy}, 32'd0);
    check_eq("tt_persist", {24'd0, tt_captured}, {24'd0, ett});
    check_eq("pass_persist", {31'd0, pass}, {31'd0, ep});
  endtask

  initial begin
    int n;
    int d0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_pass", {31'd0, pass}, 32'd0);
    check_eq("rst_tt", {24'd0, tt_captured}, 32'd0);
    check_eq("rst_mismatch", {24'd0, mismatch}, 32'd0);
    check_eq("rst_drv", {29'd0, r}, 32'd0);
    check_eq("rst_unstable", {24'd0, unst_obs}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(0, 8'h89, 1'b1, 8'h00, 1'b0);
    run_sweep(1, 8'h00, 1'b0, 8'h00, 1'b0);
    run_sweep(2, 8'h76, 1'b0, 8'h00, 1'b0);
    run_sweep(0, 8'h89, 1'b1, 8'h00, 1'b1);

    // Reset in the middle of row 5: everything clears at once, no done pulse.
    mode = 0;
    d0 = done_cnt;
    push_exp(8'h89, 1'b1, 8'h00);
    pulse_start();
    n = 0;
    @(negedge clk);
    while (r != 3'd5 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("reached_row5", {29'd0, r}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_drv", {29'd0, r}, 32'd0);
    check_eq("midrst_tt", {24'd0, tt_captured}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (Lat) @(negedge clk);
    check_eq("midrst_no_done", done_cnt - d0, 0);
    run_sweep(0, 8'h89, 1'b1, 8'h00, 1'b0);

`ifdef TT_SWEEP_STABILITY_CHECK_EN
    run_sweep(3, 8'h89, 1'b0, 8'h20, 1'b0);
    check_eq("unstable_persist", {24'd0, unst_obs}, 32'h20);
    run_sweep(0, 8'h89, 1'b1, 8'h00, 1'b0);
`endif

    check_eq("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
